// File: rtl/warmup_pkg.sv
// warmup_pkg: state encoding and default band limits/warm-up times for bubble_warmup_ctrl
package warmup_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_ARM_CLR,
    S_ARM_START,
    S_WAIT,
    S_READY,
    S_FAULT
  } state_t;
  localparam logic [7:0]  COLD_LIMIT_D     = 8'd40;
  localparam logic [7:0]  WARM_LIMIT_D     = 8'd80;
  localparam logic [7:0]  OVERTEMP_LIMIT_D = 8'd200;
  localparam logic [15:0] T_COLD_D         = 16'd30;
  localparam logic [15:0] T_WARM_D         = 16'd10;
  localparam logic [15:0] T_HOT_D          = 16'd2;
endpackage

// File: rtl/warmup_band_lut.sv
// warmup_band_lut: maps a temperature code to its warm-up threshold and an overtemp flag
//   i_code  in  8   unsigned temperature sample
//   o_thr   out 16  warm-up seconds for the band of i_code
//   o_over  out 1   i_code at or above the overtemp limit
module warmup_band_lut
  import warmup_pkg::*;
#(
  parameter logic [7:0]  COLD_LIMIT     = COLD_LIMIT_D,
  parameter logic [7:0]  WARM_LIMIT     = WARM_LIMIT_D,
  parameter logic [7:0]  OVERTEMP_LIMIT = OVERTEMP_LIMIT_D,
  parameter logic [15:0] T_COLD         = T_COLD_D,
  parameter logic [15:0] T_WARM         = T_WARM_D,
  parameter logic [15:0] T_HOT          = T_HOT_D
) (
  input  logic [7:0]  i_code,
  output logic [15:0] o_thr,
  output logic        o_over
);
  assign o_thr  = i_code < COLD_LIMIT ? T_COLD : i_code < WARM_LIMIT ? T_WARM : T_HOT;
  assign o_over = i_code >= OVERTEMP_LIMIT;
endmodule

// File: rtl/bubble_warmup_ctrl.sv
// bubble_warmup_ctrl: temperature-based warm-up sequencer for the bubble module
//   MCLK in, nRESET in (sync active-low), nENABLE in (low = operate), TEMPCODE[7:0] in,
//   TEMPVALID in, TIMEELAPSED[15:0] in, OVFL in, TC_nRESET out, TC_nSTART out,
//   nHEATEREN out, nBUBBLEREADY out, FAULT out (sticky),
//   REMAIN[15:0] out only when WARMUP_REMAIN_EN is defined (seconds left in WAIT).
module bubble_warmup_ctrl
  import warmup_pkg::*;
#(
  parameter logic [7:0]  COLD_LIMIT     = COLD_LIMIT_D,
  parameter logic [7:0]  WARM_LIMIT     = WARM_LIMIT_D,
  parameter logic [7:0]  OVERTEMP_LIMIT = OVERTEMP_LIMIT_D,
  parameter logic [15:0] T_COLD         = T_COLD_D,
  parameter logic [15:0] T_WARM         = T_WARM_D,
  parameter logic [15:0] T_HOT          = T_HOT_D
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        nENABLE,
  input  logic [7:0]  TEMPCODE,
  input  logic        TEMPVALID,
  input  logic [15:0] TIMEELAPSED,
  input  logic        OVFL,
  output logic        TC_nRESET,
  output logic        TC_nSTART,
  output logic        nHEATEREN,
  output logic        nBUBBLEREADY,
  output logic        FAULT
`ifdef WARMUP_REMAIN_EN
  ,
  output logic [15:0] REMAIN
`endif
);
  state_t      r_state, w_next;
  logic [15:0] r_thr, w_thr;
  logic        w_over;
  logic        r_tc_nreset, r_tc_nstart, r_nheater, r_nready, r_fault;
  warmup_band_lut #(
    .COLD_LIMIT(COLD_LIMIT), .WARM_LIMIT(WARM_LIMIT), .OVERTEMP_LIMIT(OVERTEMP_LIMIT),
    .T_COLD(T_COLD), .T_WARM(T_WARM), .T_HOT(T_HOT)
  ) u_lut (
    .i_code(TEMPCODE),
    .o_thr (w_thr),
    .o_over(w_over)
  );
  // Overtemp outranks a disable request, which outranks the normal sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = nENABLE ? S_IDLE : S_SAMPLE;
      S_SAMPLE:    w_next = TEMPVALID ? S_ARM_CLR : S_SAMPLE;
      S_ARM_CLR:   w_next = S_ARM_START;
      S_ARM_START: w_next = S_WAIT;
      S_WAIT:      w_next = OVFL ? S_FAULT : (TIMEELAPSED >= r_thr ? S_READY : S_WAIT);
      default:     w_next = r_state;
    endcase
    if (r_state != S_IDLE && r_state != S_FAULT && nENABLE) w_next = S_IDLE;
    if (r_state != S_FAULT && TEMPVALID && w_over) w_next = S_FAULT;
  end
  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      r_state     <= S_IDLE;
      r_thr       <= '0;
      r_tc_nreset <= 1'b0;
      r_tc_nstart <= 1'b1;
      r_nheater   <= 1'b1;
      r_nready    <= 1'b1;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_next;
      if (r_state == S_SAMPLE && TEMPVALID) r_thr <= w_thr;
      // Counter is cleared when arming, held clear in FAULT, and pulsed clear when dropping back to IDLE.
      r_tc_nreset <= !(w_next == S_ARM_CLR || w_next == S_FAULT || (w_next == S_IDLE && r_state != S_IDLE));
      r_tc_nstart <= w_next != S_ARM_START;
      r_nheater   <= w_next == S_IDLE || w_next == S_FAULT;
      r_nready    <= w_next != S_READY;
      r_fault     <= w_next == S_FAULT;
    end
  end
  assign TC_nRESET    = r_tc_nreset;
  assign TC_nSTART    = r_tc_nstart;
  assign nHEATEREN    = r_nheater;
  assign nBUBBLEREADY = r_nready;
  assign FAULT        = r_fault;
`ifdef WARMUP_REMAIN_EN
  logic [15:0] r_remain;
  always_ff @(posedge MCLK) begin
    if (!nRESET) r_remain <= 16'hFFFF;
    else r_remain <= w_next == S_WAIT ? (TIMEELAPSED >= r_thr ? 16'd0 : r_thr - TIMEELAPSED) :
                     w_next == S_READY ? 16'd0 : 16'hFFFF;
  end
  assign REMAIN = r_remain;
`endif
endmodule

// File: tb/tb_bubble_warmup_ctrl.sv
// tb_bubble_warmup_ctrl: directed + randomized checks of bubble_warmup_ctrl against a band/counter model
module tb_bubble_warmup_ctrl;
  logic        MCLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        nENABLE = 1'b1;
  logic [7:0]  TEMPCODE = 8'd0;
  logic        TEMPVALID = 1'b0;
  logic [15:0] TIMEELAPSED = 16'd0;
  logic        OVFL = 1'b0;
  logic        TC_nRESET, TC_nSTART, nHEATEREN, nBUBBLEREADY, FAULT;
`ifdef WARMUP_REMAIN_EN
  logic [15:0] REMAIN;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic running = 1'b0;
  bubble_warmup_ctrl dut (
    .MCLK(MCLK), .nRESET(nRESET), .nENABLE(nENABLE), .TEMPCODE(TEMPCODE),
    .TEMPVALID(TEMPVALID), .TIMEELAPSED(TIMEELAPSED), .OVFL(OVFL),
    .TC_nRESET(TC_nRESET), .TC_nSTART(TC_nSTART), .nHEATEREN(nHEATEREN),
    .nBUBBLEREADY(nBUBBLEREADY), .FAULT(FAULT)
`ifdef WARMUP_REMAIN_EN
    , .REMAIN(REMAIN)
`endif
  );
  always #5 MCLK = ~MCLK;
  function automatic logic [15:0] band_thr(input int code);
    if (code < 40) return 16'd30;
    if (code < 80) return 16'd10;
    return 16'd2;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // One clock; the counter model reacts to the pin levels present before the edge,
  // like the real elapsed-seconds counter (1 second per clock here).
  task automatic tick();
    logic p_nres, p_nst;
    p_nres = TC_nRESET;
    p_nst  = TC_nSTART;
    @(posedge MCLK);
    #1;
    if (!p_nres) begin
      running = 1'b0;
      TIMEELAPSED = 16'd0;
    end else if (!p_nst) begin
      running = 1'b1;
      TIMEELAPSED = 16'd0;
    end else if (running) TIMEELAPSED = TIMEELAPSED + 16'd1;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tcnreset"}, {15'd0, TC_nRESET}, 16'd0);
    chk({tag, "_tcnstart"}, {15'd0, TC_nSTART}, 16'd1);
    chk({tag, "_nheat"}, {15'd0, nHEATEREN}, 16'd1);
    chk({tag, "_nready"}, {15'd0, nBUBBLEREADY}, 16'd1);
    chk({tag, "_fault"}, {15'd0, FAULT}, 16'd0);
  endtask
  // From IDLE: enable, strobe a sample, and step through the two arming pulses into WAIT.
  task automatic arm(input logic [7:0] code);
    nENABLE = 1'b0;
    tick();
    chk("sample_nheat", {15'd0, nHEATEREN}, 16'd0);
    repeat ($urandom_range(0, 3)) tick();
    TEMPCODE = code;
    TEMPVALID = 1'b1;
    tick();
    TEMPVALID = 1'b0;
    TEMPCODE = 8'($urandom_range(0, 199));
    chk("armclr_tcnreset", {15'd0, TC_nRESET}, 16'd0);
    chk("armclr_tcnstart", {15'd0, TC_nSTART}, 16'd1);
    tick();
    chk("armstart_tcnreset", {15'd0, TC_nRESET}, 16'd1);
    chk("armstart_tcnstart", {15'd0, TC_nSTART}, 16'd0);
    tick();
    chk("wait_tcnstart", {15'd0, TC_nSTART}, 16'd1);
    chk("wait_te0", TIMEELAPSED, 16'd0);
    chk("wait_nready", {15'd0, nBUBBLEREADY}, 16'd1);
  endtask
  // Ready must come one clock after the counter first shows the band threshold.
  task automatic wait_ready(input logic [15:0] thr);
    logic [15:0] prev;
    int budget;
    prev = 16'hFFFF;
    budget = 200;
    while (nBUBBLEREADY !== 1'b0 && budget > 0) begin
      prev = TIMEELAPSED;
      tick();
      budget--;
    end
    chk("ready_reached", {15'd0, nBUBBLEREADY}, 16'd0);
    chk("ready_at_te", prev, thr);
    chk("ready_nheat", {15'd0, nHEATEREN}, 16'd0);
  endtask
  task automatic go_idle();
    nENABLE = 1'b1;
    tick();
    chk("idle_nready", {15'd0, nBUBBLEREADY}, 16'd1);
    chk("idle_nheat", {15'd0, nHEATEREN}, 16'd1);
    chk("idle_tcpulse", {15'd0, TC_nRESET}, 16'd0);
    tick();
    chk("idle_tcrelease", {15'd0, TC_nRESET}, 16'd1);
  endtask
  task automatic do_reset();
    nRESET = 1'b0;
    nENABLE = 1'b1;
    OVFL = 1'b0;
    TEMPVALID = 1'b0;
    tick();
    check_reset_outputs("rst");
    nRESET = 1'b1;
    tick();
    chk("post_rst_tcnreset", {15'd0, TC_nRESET}, 16'd1);
  endtask
  initial begin
    tick();
    tick();
    check_reset_outputs("por");
    nRESET = 1'b1;
    tick();
    chk("idle_tcnreset", {15'd0, TC_nRESET}, 16'd1);
    chk("idle_nheat0", {15'd0, nHEATEREN}, 16'd1);
    // Cold band, then OVFL while READY is ignored.
    arm(8'd20);
    wait_ready(16'd30);
    OVFL = 1'b1;
    tick();
    tick();
    chk("ready_ovfl_nready", {15'd0, nBUBBLEREADY}, 16'd0);
    chk("ready_ovfl_fault", {15'd0, FAULT}, 16'd0);
    OVFL = 1'b0;
    go_idle();
    // Band edges and neighbours.
    arm(8'd40); wait_ready(16'd10); go_idle();
    arm(8'd80); wait_ready(16'd2); go_idle();
    arm(8'd79); wait_ready(16'd10); go_idle();
    arm(8'd39); wait_ready(16'd30); go_idle();
    arm(8'd199); wait_ready(16'd2); go_idle();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] c;
      c = 8'($urandom_range(0, 199));
      arm(c);
      wait_ready(band_thr(int'(c)));
      go_idle();
    end
    // Disable in the middle of WAIT.
    arm(8'd10);
    repeat (4) tick();
    go_idle();
    // Counter overflow during WAIT.
    arm(8'd20);
    repeat (5) tick();
    OVFL = 1'b1;
    tick();
    OVFL = 1'b0;
    chk("ovfl_fault", {15'd0, FAULT}, 16'd1);
    chk("ovfl_nheat", {15'd0, nHEATEREN}, 16'd1);
    chk("ovfl_nready", {15'd0, nBUBBLEREADY}, 16'd1);
    chk("ovfl_tcnreset", {15'd0, TC_nRESET}, 16'd0);
    nENABLE = 1'b1; tick(); nENABLE = 1'b0; tick(); tick();
    chk("fault_sticky", {15'd0, FAULT}, 16'd1);
    chk("fault_tcheld", {15'd0, TC_nRESET}, 16'd0);
    do_reset();
    // Overtemp sample during WAIT.
    arm(8'd50);
    repeat (3) tick();
    TEMPCODE = 8'd200;
    TEMPVALID = 1'b1;
    tick();
    TEMPVALID = 1'b0;
    chk("otemp_fault", {15'd0, FAULT}, 16'd1);
    chk("otemp_nheat", {15'd0, nHEATEREN}, 16'd1);
    nENABLE = 1'b1; tick(); tick();
    chk("otemp_sticky", {15'd0, FAULT}, 16'd1);
    do_reset();
    // Overtemp at the first sample beats arming.
    nENABLE = 1'b0;
    tick();
    TEMPCODE = 8'($urandom_range(200, 255));
    TEMPVALID = 1'b1;
    tick();
    TEMPVALID = 1'b0;
    chk("sample_otemp_fault", {15'd0, FAULT}, 16'd1);
    chk("sample_otemp_nstart", {15'd0, TC_nSTART}, 16'd1);
    do_reset();
    // Reset in the middle of WAIT.
    arm(8'd20);
    repeat (3) tick();
    nRESET = 1'b0;
    tick();
    check_reset_outputs("midrst");
    nRESET = 1'b1;
    nENABLE = 1'b1;
    tick();
`ifdef WARMUP_REMAIN_EN
    chk("remain_idle", REMAIN, 16'hFFFF);
    arm(8'd60);
    while (TIMEELAPSED < 16'd7) tick();
    tick();
    chk("remain_te7", REMAIN, 16'd3);
    wait_ready(16'd10);
    chk("remain_ready", REMAIN, 16'd0);
    go_idle();
    chk("remain_back_idle", REMAIN, 16'hFFFF);
`endif
    // Re-sample after all of the above still works.
    arm(8'd100); wait_ready(16'd2); go_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end
endmodule
